// File: rtl/pcie_led_status.sv
// LED status engine: lamp test after reset, heartbeat while the PCIe link is down,
// pulse-stretched per-channel activity once it is up. Define LED_PWM_EN to build PWM dimming.
module pcie_led_status #(
   parameter int NUM_CH         = 4,
   parameter int STRETCH_CYCLES = 2500000,
   parameter int HB_HALF        = 25000000,
   parameter int LAMP_CYCLES    = 50000000,
   parameter int PWM_W          = 4
) (
   input  logic              bus_clk,
   input  logic              bus_rst,
   input  logic              link_up,
   input  logic [NUM_CH-1:0] activity,
   input  logic [PWM_W-1:0]  brightness,
   output logic [NUM_CH-1:0] led,
   output logic [1:0]        state_o
);

   localparam int SW = $clog2(STRETCH_CYCLES + 1);
   localparam int HW = $clog2(HB_HALF + 1);
   localparam int LW = $clog2(LAMP_CYCLES + 1);

   localparam logic [SW-1:0] StretchLoad = SW'(STRETCH_CYCLES);
   localparam logic [HW-1:0] HbLast      = HW'(HB_HALF - 1);
   localparam logic [LW-1:0] LampLast    = LW'(LAMP_CYCLES - 1);

   typedef enum logic [1:0] {
      StLamp = 2'b00,
      StDown = 2'b01,
      StUp   = 2'b10
   } state_e;

   state_e                   state_q, state_d;
   logic                     linkMeta_q, linkS_q;
   logic [HW-1:0]            hbCnt_q, hbCnt_d;
   logic                     hb_q, hb_d;
   logic [LW-1:0]            lampCnt_q, lampCnt_d;
   logic [NUM_CH-1:0][SW-1:0] stretch_q, stretch_d;
   logic [NUM_CH-1:0]        rawLed;
   logic [NUM_CH-1:0]        led_q, led_d;

   // link_up comes from the PCIe core clock domain
   always_ff @(posedge bus_clk or posedge bus_rst) begin
      if (bus_rst) begin
         linkMeta_q <= 1'b0;
         linkS_q    <= 1'b0;
      end else begin
         linkMeta_q <= link_up;
         linkS_q    <= linkMeta_q;
      end
   end

   // Heartbeat is free-running in every state so the blink phase never jumps
   always_comb begin
      hbCnt_d = hbCnt_q + HW'(1);
      hb_d    = hb_q;
      if (hbCnt_q == HbLast) begin
         hbCnt_d = '0;
         hb_d    = ~hb_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      lampCnt_d = lampCnt_q;
      stretch_d = stretch_q;
      rawLed    = '0;
      unique case (state_q)
         StLamp: begin
            rawLed = '1;
            if (lampCnt_q == LampLast) begin
               state_d = StDown;
            end else begin
               lampCnt_d = lampCnt_q + LW'(1);
            end
         end
         StDown: begin
            rawLed    = {NUM_CH{hb_q}};
            stretch_d = '0;
            if (linkS_q) begin
               state_d = StUp;
            end
         end
         StUp: begin
            for (int i = 0; i < NUM_CH; i++) begin
               rawLed[i] = (stretch_q[i] != '0);
            end
            rawLed[0] = rawLed[0] | hb_q;
            // A link drop overrides any activity seen in the same cycle
            if (!linkS_q) begin
               state_d   = StDown;
               stretch_d = '0;
            end else begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (activity[i]) begin
                     stretch_d[i] = StretchLoad;
                  end else if (stretch_q[i] != '0) begin
                     stretch_d[i] = stretch_q[i] - SW'(1);
                  end
               end
            end
         end
         default: begin
            state_d = StLamp;
         end
      endcase
   end

`ifdef LED_PWM_EN
   logic [PWM_W-1:0] pwmCnt_q;
   logic             pwmOn;

   always_ff @(posedge bus_clk or posedge bus_rst) begin
      if (bus_rst) begin
         pwmCnt_q <= '0;
      end else begin
         pwmCnt_q <= pwmCnt_q + PWM_W'(1);
      end
   end

   assign pwmOn = (pwmCnt_q < brightness);

   // The lamp test must always be full brightness
   always_comb begin
      led_d = rawLed & {NUM_CH{pwmOn}};
      if (state_q == StLamp) begin
         led_d = rawLed;
      end
   end
`else
   logic unusedBrightness;

   assign unusedBrightness = ^brightness;

   always_comb begin
      led_d = rawLed;
   end
`endif

   always_ff @(posedge bus_clk or posedge bus_rst) begin
      if (bus_rst) begin
         state_q   <= StLamp;
         hbCnt_q   <= '0;
         hb_q      <= 1'b0;
         lampCnt_q <= '0;
         stretch_q <= '0;
         led_q     <= '0;
      end else begin
         state_q   <= state_d;
         hbCnt_q   <= hbCnt_d;
         hb_q      <= hb_d;
         lampCnt_q <= lampCnt_d;
         stretch_q <= stretch_d;
         led_q     <= led_d;
      end
   end

   assign led     = led_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_pcie_led_status.sv
// Directed testbench for pcie_led_status: lamp test, heartbeat, link up/down,
// pulse stretching, retrigger, drop priority, async reset and (with LED_PWM_EN) dimming.
module tb_pcie_led_status;

   localparam int NumCh   = 4;
   localparam int Stretch = 8;
   localparam int HbHalf  = 4;
   localparam int Lamp    = 6;
   localparam int PwmW    = 2;

   logic             bus_clk = 1'b0;
   logic             bus_rst = 1'b1;
   logic             link_up = 1'b0;
   logic [NumCh-1:0] activity = '0;
   logic [PwmW-1:0]  brightness = '0;
   logic [NumCh-1:0] led;
   logic [1:0]       state_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [3:0] act;
      logic       lnk;
      logic [3:0] expLed;
      logic [1:0] expState;
   } vec_t;

   vec_t vecs [36];

   always #5 bus_clk = ~bus_clk;

   pcie_led_status #(
      .NUM_CH(NumCh),
      .STRETCH_CYCLES(Stretch),
      .HB_HALF(HbHalf),
      .LAMP_CYCLES(Lamp),
      .PWM_W(PwmW)
   ) dut (
      .bus_clk(bus_clk),
      .bus_rst(bus_rst),
      .link_up(link_up),
      .activity(activity),
      .brightness(brightness),
      .led(led),
      .state_o(state_o)
   );

   // One bus_clk period; inputs are driven and outputs sampled on the falling edge
   task automatic step();
      @(negedge bus_clk);
      cyc++;
   endtask

   task automatic applyStimulus(input logic [3:0] act, input logic lnk);
      activity = act;
      link_up  = lnk;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
      end
   endtask

   function automatic logic hbAt(input int k);
      return ((k / HbHalf) % 2) != 0;
   endfunction

   // Expected led for the current cycle given the undimmed value and whether the
   // previous cycle was the lamp test
   function automatic logic [3:0] maskLed(input logic [3:0] v, input logic prevLamp);
      logic pwmOn;
`ifdef LED_PWM_EN
      pwmOn = (((cyc - 1) % 4) < int'(brightness));
`else
      pwmOn = 1'b1;
`endif
      return (prevLamp || pwmOn) ? v : 4'b0000;
   endfunction

   initial begin
      logic [3:0] expL;
      logic       prevLamp;
      int         s;
      int         c;
      int         on;

      vecs[0]  = '{4'h0, 1'b0, 4'hF, 2'd0};
      vecs[1]  = '{4'h0, 1'b0, 4'hF, 2'd0};
      vecs[2]  = '{4'h0, 1'b0, 4'hF, 2'd0};
      vecs[3]  = '{4'h0, 1'b0, 4'hF, 2'd0};
      vecs[4]  = '{4'h0, 1'b0, 4'hF, 2'd0};
      vecs[5]  = '{4'h0, 1'b0, 4'hF, 2'd1};
      vecs[6]  = '{4'h0, 1'b0, 4'hF, 2'd1};
      vecs[7]  = '{4'h0, 1'b0, 4'hF, 2'd1};
      vecs[8]  = '{4'h0, 1'b0, 4'h0, 2'd1};
      vecs[9]  = '{4'h0, 1'b0, 4'h0, 2'd1};
      vecs[10] = '{4'h0, 1'b0, 4'h0, 2'd1};
      vecs[11] = '{4'h0, 1'b0, 4'h0, 2'd1};
      vecs[12] = '{4'h0, 1'b0, 4'hF, 2'd1};
      vecs[13] = '{4'h0, 1'b0, 4'hF, 2'd1};
      vecs[14] = '{4'h0, 1'b0, 4'hF, 2'd1};
      vecs[15] = '{4'h0, 1'b0, 4'hF, 2'd1};
      vecs[16] = '{4'h0, 1'b1, 4'h0, 2'd1};
      vecs[17] = '{4'h0, 1'b1, 4'h0, 2'd1};
      vecs[18] = '{4'h0, 1'b1, 4'h0, 2'd2};
      vecs[19] = '{4'h0, 1'b1, 4'h0, 2'd2};
      vecs[20] = '{4'h0, 1'b1, 4'h1, 2'd2};
      vecs[21] = '{4'h0, 1'b1, 4'h1, 2'd2};
      vecs[22] = '{4'h0, 1'b1, 4'h1, 2'd2};
      vecs[23] = '{4'h0, 1'b1, 4'h1, 2'd2};
      vecs[24] = '{4'h0, 1'b1, 4'h0, 2'd2};
      vecs[25] = '{4'h4, 1'b1, 4'h0, 2'd2};
      vecs[26] = '{4'h0, 1'b1, 4'h4, 2'd2};
      vecs[27] = '{4'h0, 1'b1, 4'h4, 2'd2};
      vecs[28] = '{4'h0, 1'b1, 4'h5, 2'd2};
      vecs[29] = '{4'h0, 1'b1, 4'h5, 2'd2};
      vecs[30] = '{4'h0, 1'b1, 4'h5, 2'd2};
      vecs[31] = '{4'h0, 1'b1, 4'h5, 2'd2};
      vecs[32] = '{4'h0, 1'b1, 4'h4, 2'd2};
      vecs[33] = '{4'h0, 1'b1, 4'h4, 2'd2};
      vecs[34] = '{4'h0, 1'b1, 4'h0, 2'd2};
      vecs[35] = '{4'h0, 1'b1, 4'h0, 2'd2};

`ifdef LED_PWM_EN
      brightness = 2'd3;
`else
      brightness = 2'd0;
`endif

      #12;
      checkOutput("reset led", 32'(led), 32'h0);
      checkOutput("reset state", 32'(state_o), 32'h0);

      @(negedge bus_clk);
      bus_rst = 1'b0;
      cyc     = 0;

      // Lamp test, heartbeat in DOWN, link up, single activity pulse on ch2
      for (int n = 0; n < 36; n++) begin
         applyStimulus(vecs[n].act, vecs[n].lnk);
         step();
         prevLamp = (n == 0) ? 1'b1 : (vecs[n-1].expState == 2'd0);
         checkOutput($sformatf("vec%0d led", n), 32'(led), 32'(maskLed(vecs[n].expLed, prevLamp)));
         checkOutput($sformatf("vec%0d state", n), 32'(state_o), 32'(vecs[n].expState));
      end

      // Retrigger on ch2 five cycles after the first strobe
      s = cyc;
      applyStimulus(4'b0100, 1'b1);
      for (int j = 1; j <= 16; j++) begin
         step();
         applyStimulus((j == 5) ? 4'b0100 : 4'b0000, 1'b1);
         expL = maskLed(((cyc >= s + 2) && (cyc <= s + 14)) ? 4'b0100 : 4'b0000, 1'b0);
         checkOutput("retrigger led2", 32'(led[2]), 32'(expL[2]));
      end

      // Link drop coinciding with activity on ch1
      c = cyc;
      applyStimulus(4'b0010, 1'b1);
      step();
      applyStimulus(4'b0000, 1'b1);
      step();
      step();
      applyStimulus(4'b0010, 1'b0);
      step();
      step();
      checkOutput("pre-drop state", 32'(state_o), 32'd2);
      step();
      checkOutput("drop state", 32'(state_o), 32'd1);
      applyStimulus(4'b0000, 1'b0);
      for (int j = 0; j < 4; j++) begin
         step();
         checkOutput("down led", 32'(led), 32'(maskLed({4{hbAt(cyc - 1)}}, 1'b0)));
         checkOutput("down state", 32'(state_o), 32'd1);
      end
      applyStimulus(4'b0000, 1'b1);
      step();
      step();
      step();
      checkOutput("relink state", 32'(state_o), 32'd2);
      step();
      checkOutput("relink led", 32'(led), 32'(maskLed({3'b000, hbAt(cyc - 1)}, 1'b0)));
      if (cyc != c + 14) begin
         checkOutput("drop sequence length", 32'(cyc), 32'(c + 14));
      end

`ifndef LED_PWM_EN
      // Strobe held for three cycles stretches to 3 + STRETCH - 1 on-cycles
      on = 0;
      applyStimulus(4'b1000, 1'b1);
      for (int j = 1; j <= 16; j++) begin
         step();
         applyStimulus((j < 3) ? 4'b1000 : 4'b0000, 1'b1);
         if (led[3]) on++;
      end
      checkOutput("held strobe on-cycles", 32'(on), 32'd10);
`endif

      // Asynchronous reset in the middle of a stretch, link stays up
      applyStimulus(4'b1111, 1'b1);
      step();
      applyStimulus(4'b0000, 1'b1);
      step();
      step();
      #2;
      bus_rst = 1'b1;
      #1;
      checkOutput("async reset led", 32'(led), 32'h0);
      checkOutput("async reset state", 32'(state_o), 32'h0);
      @(negedge bus_clk);
      bus_rst = 1'b0;
      cyc     = 0;
      for (int k = 1; k <= 8; k++) begin
         step();
         expL = maskLed((k <= 7) ? 4'hF : 4'h1, (k <= 6));
         checkOutput("relamp led", 32'(led), 32'(expL));
         checkOutput("relamp state", 32'(state_o), (k <= 5) ? 32'd0 : ((k == 6) ? 32'd1 : 32'd2));
      end

`ifdef LED_PWM_EN
      // Dimming with ch3 held active
      applyStimulus(4'b1000, 1'b1);
      for (int b = 0; b < 4; b++) begin
         if (b == 1) continue;
         brightness = 2'(b);
         repeat (4) step();
         on = 0;
         for (int j = 0; j < 8; j++) begin
            step();
            if (led[3]) on++;
         end
         checkOutput($sformatf("pwm b=%0d on-cycles", b), 32'(on), 32'(2 * b));
      end

      // Lamp test ignores brightness
      brightness = 2'd0;
      @(negedge bus_clk);
      bus_rst = 1'b1;
      @(negedge bus_clk);
      bus_rst = 1'b0;
      cyc     = 0;
      for (int k = 1; k <= 6; k++) begin
         step();
         checkOutput("pwm lamp led", 32'(led), 32'hF);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pcie_led_status.md
Name: pcie_led_status

Overview:
- Parametrised LED status engine for the eval-board top level; drives the board GPIO LEDs from the PCIe/Xillybus side.
- Runs a lamp test after reset, shows a heartbeat while the PCIe link is down, then per-channel activity with pulse stretching once the link is up.
- Generalises the fixed 4-LED passthrough to NUM_CH channels, with configurable timing and optional PWM dimming.

Parameters:
- NUM_CH, 4, number of LED/activity channels (1..16)
- STRETCH_CYCLES, 2500000, minimum LED on-time in cycles after an activity pulse (>=2)
- HB_HALF, 25000000, heartbeat half-period in cycles (>=2)
- LAMP_CYCLES, 50000000, lamp-test duration after reset (>=1)
- PWM_W, 4, brightness resolution in bits (used only with LED_PWM_EN)

Ports:
- bus_clk  in  1  single clock for all logic
- bus_rst  in  1  asynchronous reset, active-high
- link_up  in  1  PCIe user link-up, asynchronous to bus_clk; synchronised internally
- activity  in  NUM_CH  per-channel activity strobes, bus_clk domain, any pulse width
- brightness  in  PWM_W  LED duty setting, quasi-static
- led  out  NUM_CH  LED drive, active-high, registered
- state_o  out  2  current FSM state (00 LAMP, 01 DOWN, 10 UP), for debug

Behaviour:
- Reset (async assert, sync release): led=0, state_o=00, all counters 0, sync flops 0. FSM enters LAMP on the first edge after release.
- link_up synchronisation:
  - 2-flop synchroniser; link_s is the second flop.
  - A change on link_up is visible to the FSM 2 cycles later.
- FSM:
  - LAMP: raw led = all ones for exactly LAMP_CYCLES cycles, then -> DOWN.
  - DOWN: raw led = all channels = hb; activity is ignored and stretch counters are held at 0. link_s=1 -> UP.
  - UP: raw led[i] = (stretch_cnt[i]!=0), except ch0, which shows hb while stretch_cnt[0]==0. link_s=0 -> DOWN; all stretch counters clear on that same edge.
  - LAMP ignores link_s. A link transition during LAMP takes effect on the first DOWN cycle.
- Heartbeat:
  - hb_cnt counts 0..HB_HALF-1 and wraps; hb toggles on each wrap.
  - hb_cnt runs in every state and is reset only by bus_rst.
- Stretch, per channel, in UP only:
  - activity[i]=1 loads stretch_cnt[i]=STRETCH_CYCLES.
  - Otherwise stretch_cnt[i] decrements if nonzero.
  - Retrigger while counting reloads to the full value. This is not additive and causes no glitch on led.
  - A single-cycle strobe at cycle t gives led[i]=1 from t+1 through t+STRETCH_CYCLES inclusive.
  - A strobe held high for N cycles gives N+STRETCH_CYCLES-1 on-cycles.
- Output latency: led is registered, one cycle after the raw value.
- Width rules:
  - Counter widths are $clog2(max+1) of their respective parameters.
  - No counter may overflow or wrap except hb_cnt.
- Simultaneous events: link drop and activity in the same cycle -> the drop wins, counters clear, and the FSM goes to DOWN.
- Reset mid-operation: everything returns to the reset values immediately (asynchronously); the lamp test restarts.

Optional Feature:
- Macro: LED_PWM_EN
- Defined:
  - Free-running PWM_W-bit pwm_cnt; final led[i] = raw[i] & (pwm_cnt < brightness), registered.
  - brightness=0 -> LEDs always off.
  - brightness=2^PWM_W-1 -> on 2^PWM_W-1 of every 2^PWM_W cycles.
  - LAMP state bypasses PWM and is always full on.
- Undefined:
  - brightness is ignored and no pwm_cnt is built; led = registered raw value.

Test Plan:
Use NUM_CH=4, STRETCH_CYCLES=8, HB_HALF=4, LAMP_CYCLES=6, PWM_W=2 for all scenarios.
1. Reset release, link_up=0 -> led=1111 for cycles 1..6 after the LAMP entry edge; then state_o=01 and led toggles between 0000 and 1111 every 4 cycles.
2. link_up 0->1 in DOWN -> state_o=10 within 3 cycles; activity=0000 -> led=000x with ch0 following hb.
3. UP, 1-cycle pulse activity[2] at cycle t -> led[2]=1 for cycles t+1..t+8 exactly, 0 at t+9; pulse again at t+5 -> led[2] stays 1 through t+13.
4. UP, activity[1] strobed at cycle t; link_up drops at t+3 (same cycle as a new activity[1] strobe) -> state_o=01 two cycles after the drop; led follows hb on all channels; stretch counters read 0.
5. bus_rst asserted mid-stretch in UP -> led=0000 and state_o=00 without waiting for a clock edge; after release the 6-cycle lamp test repeats.
6. LED_PWM_EN defined, UP, activity[3] held at 1:
   - brightness=0 -> led[3]=0 always.
   - brightness=2 -> led[3] high 2 of every 4 cycles.
   - brightness=3 -> high 3 of 4.
   - During LAMP, led=1111 regardless of brightness.
